bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_seq.sv | 116 +++++++++++
 tb/tb_bin2bcd_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Accepts on in_valid && in_ready; presents bcd/ovf with a one-cycle out_valid strobe.
module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [BW-1:0]     work_q, work_d;
  logic              ovf_acc_q, ovf_acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              ovf_q, ovf_d;

  logic [BW-1:0]     corr;
  logic [BW-1:0]     work_shift;
  logic              ovf_shift;
  logic              accept;

  // Per-digit add-3 correction; a corrected digit is at most 12, so no carries.
  always_comb begin
    corr = work_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) begin
        corr[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Bit 3 of the top corrected digit leaves the register and marks overflow.
  assign work_shift = {corr[BW-2:0], bin_q[BIN_W-1]};
  assign ovf_shift  = ovf_acc_q | corr[BW-1];

  assign in_ready  = (state_q != SHIFT);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign bcd       = bcd_q;
  assign ovf       = ovf_q;

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    work_d    = work_q;
    ovf_acc_d = ovf_acc_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          bin_d     = bin;
          work_d    = '0;
          ovf_acc_d = 1'b0;
          cnt_d     = CW'(BIN_W);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        bin_d     = bin_q << 1;
        work_d    = work_shift;
        ovf_acc_d = ovf_shift;
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = work_shift;
          ovf_d   = ovf_shift;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      work_q    <= '0;
      ovf_acc_q <= 1'b0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      work_q    <= work_d;
      ovf_acc_q <= ovf_acc_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: default build plus 20/7 and 8/2 parameter builds.
module tb_bin2bcd_seq;

  typedef struct {
    logic [63:0] bcd;
    logic        ovf;
    int          acc;
  } exp_t;

  logic        clk;
  logic        rst;
  int          cyc;
  int          checks;
  int          errors;

  logic        iv0, ir0, ov0, ovf0;
  logic [13:0] bin0;
  logic [15:0] bcd0;
  logic        iv1, ir1, ov1, ovf1;
  logic [19:0] bin1;
  logic [27:0] bcd1;
  logic        iv2, ir2, ov2, ovf2;
  logic [7:0]  bin2;
  logic [7:0]  bcd2;

  exp_t q0[$], q1[$], q2[$];
  int   strobes0[$];
  logic prev0, prev1, prev2;
  exp_t e0, e1, e2;

  bin2bcd_seq dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .bin(bin0),
    .out_valid(ov0), .bcd(bcd0), .ovf(ovf0)
  );

  bin2bcd_seq #(.BIN_W(20), .DIGITS(7)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .bin(bin1),
    .out_valid(ov1), .bcd(bcd1), .ovf(ovf1)
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .bin(bin2),
    .out_valid(ov2), .bcd(bcd2), .ovf(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] to_bcd(input longint v, input int d);
    logic [63:0] r;
    longint      x;
    r = '0;
    x = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic too_big(input longint v, input int d);
    longint p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return (v >= p);
  endfunction

  // Monitors: pop the scoreboard on each strobe and check value, overflow, latency, width.
  always @(negedge clk) begin
    if (ov0) begin
      check_eq("ov0_one_cycle", 64'(prev0), 64'd0);
      if (q0.size() == 0) begin
        check_eq("ov0_unexpected", 64'd1, 64'd0);
      end else begin
        e0 = q0.pop_front();
        check_eq("bcd0", 64'(bcd0), e0.bcd);
        check_eq("ovf0", 64'(ovf0), 64'(e0.ovf));
        check_eq("lat0", 64'(cyc - e0.acc + 1), 64'd15);
        strobes0.push_back(cyc);
      end
    end
    prev0 = ov0;
  end

  always @(negedge clk) begin
    if (ov1) begin
      check_eq("ov1_one_cycle", 64'(prev1), 64'd0);
      if (q1.size() == 0) begin
        check_eq("ov1_unexpected", 64'd1, 64'd0);
      end else begin
        e1 = q1.pop_front();
        check_eq("bcd1", 64'(bcd1), e1.bcd);
        check_eq("ovf1", 64'(ovf1), 64'(e1.ovf));
        check_eq("lat1", 64'(cyc - e1.acc + 1), 64'd21);
      end
    end
    prev1 = ov1;
  end

  always @(negedge clk) begin
    if (ov2) begin
      check_eq("ov2_one_cycle", 64'(prev2), 64'd0);
      if (q2.size() == 0) begin
        check_eq("ov2_unexpected", 64'd1, 64'd0);
      end else begin
        e2 = q2.pop_front();
        check_eq("bcd2", 64'(bcd2), e2.bcd);
        check_eq("ovf2", 64'(ovf2), 64'(e2.ovf));
        check_eq("lat2", 64'(cyc - e2.acc + 1), 64'd9);
      end
    end
    prev2 = ov2;
  end

  // Present v on dut0, wait for in_ready, record the expectation for the accept edge.
  task automatic send0(input int v, input bit hold);
    exp_t e;
    int   n;
    bin0 = 14'(v);
    iv0  = 1'b1;
    n    = 0;
    while (!ir0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ir0) begin
      check_eq("send0_ready_timeout", 64'(ir0), 64'd1);
      iv0 = 1'b0;
    end else begin
      e.bcd = to_bcd(v, 4);
      e.ovf = too_big(v, 4);
      e.acc = cyc + 1;
      q0.push_back(e);
      @(negedge clk);
      if (!hold) iv0 = 1'b0;
    end
  endtask

  task automatic wait_idle0;
    int n;
    n = 0;
    while (q0.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0) begin
      check_eq("drain0_timeout", 64'(q0.size()), 64'd0);
      q0.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int vals[4];
    int n;
    exp_t e;
    checks = 0;
    errors = 0;
    prev0 = 1'b0; prev1 = 1'b0; prev2 = 1'b0;
    rst = 1'b1;
    iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
    bin0 = '0; bin1 = '0; bin2 = '0;
    repeat (3) @(negedge clk);

    check_eq("rst_ready0", 64'(ir0), 64'd1);
    check_eq("rst_valid0", 64'(ov0), 64'd0);
    check_eq("rst_bcd0",   64'(bcd0), 64'd0);
    check_eq("rst_ovf0",   64'(ovf0), 64'd0);
    check_eq("rst_ready1", 64'(ir1), 64'd1);
    check_eq("rst_bcd1",   64'(bcd1), 64'd0);
    check_eq("rst_ready2", 64'(ir2), 64'd1);
    check_eq("rst_bcd2",   64'(bcd2), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single conversion with in_ready low throughout SHIFT.
    send0(4567, 1'b0);
    for (int i = 0; i < 14; i++) begin
      check_eq("busy_ready0", 64'(ir0), 64'd0);
      @(negedge clk);
    end
    check_eq("done_ready0", 64'(ir0), 64'd1);
    wait_idle0();

    // Back-to-back accepts with in_valid held.
    strobes0.delete();
    send0(78, 1'b1);
    send0(67, 1'b1);
    send0(4227, 1'b0);
    wait_idle0();
    check_eq("b2b_count", 64'(strobes0.size()), 64'd3);
    if (strobes0.size() == 3) begin
      check_eq("b2b_gap_a", 64'(strobes0[1] - strobes0[0]), 64'd15);
      check_eq("b2b_gap_b", 64'(strobes0[2] - strobes0[1]), 64'd15);
    end

    // Overflow and range boundaries; the last leaves a nonzero bcd behind.
    vals = '{16383, 10000, 0, 9999};
    foreach (vals[i]) begin
      send0(vals[i], 1'b0);
      wait_idle0();
    end

    // Reset mid-conversion discards the result.
    strobes0.delete();
    send0(4567, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    q0.delete();
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_ready0", 64'(ir0), 64'd1);
    check_eq("midrst_bcd0",   64'(bcd0), 64'd0);
    check_eq("midrst_ovf0",   64'(ovf0), 64'd0);
    repeat (25) @(negedge clk);
    check_eq("midrst_no_strobe", 64'(strobes0.size()), 64'd0);
    send0(1234, 1'b0);
    wait_idle0();

    // in_valid during SHIFT is dropped.
    strobes0.delete();
    send0(4567, 1'b0);
    repeat (3) @(negedge clk);
    bin0 = 14'd9;
    iv0  = 1'b1;
    @(negedge clk);
    iv0  = 1'b0;
    wait_idle0();
    repeat (20) @(negedge clk);
    check_eq("busy_strobes", 64'(strobes0.size()), 64'd1);

    // BIN_W=20, DIGITS=7 and BIN_W=8, DIGITS=2 builds.
    bin1 = 20'd1048575;
    iv1  = 1'b1;
    bin2 = 8'd255;
    iv2  = 1'b1;
    e.bcd = to_bcd(1048575, 7); e.ovf = too_big(1048575, 7); e.acc = cyc + 1;
    q1.push_back(e);
    e.bcd = to_bcd(255, 2); e.ovf = too_big(255, 2); e.acc = cyc + 1;
    q2.push_back(e);
    @(negedge clk);
    iv1 = 1'b0;
    iv2 = 1'b0;
    n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain1", 64'(q1.size()), 64'd0);
    check_eq("drain2", 64'(q2.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
